// File: rtl/f_reg_file_ctrl_pkg.sv
// Shared types and defaults for the f-register file and its call/return snapshot controller.
package f_reg_file_ctrl_pkg;

    localparam int unsigned NREGS_DEF = 16;
    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned DEPTH_DEF = 16;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        BACKUP       = 2'd1,
        RESTORE_WAIT = 2'd2
    } state_e;

    // Width of the flat snapshot image exchanged with the backup stack.
    function automatic int unsigned snap_width(input int unsigned nregs, input int unsigned width);
        return nregs * width;
    endfunction

endpackage

// File: rtl/f_reg_array.sv
// F-register storage: one write port, two combinational read ports, full parallel load,
// and a flat snapshot of every register.
module f_reg_array
    import f_reg_file_ctrl_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned SNAP_W = snap_width(NREGS, WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              load,
    input  logic [SNAP_W-1:0] load_data,
    output logic [SNAP_W-1:0] snap
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];

    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (load) begin
                regs_d[i] = load_data[i*WIDTH +: WIDTH];
            end else if (we && (waddr == AW'(i))) begin
                regs_d[i] = wdata;
            end else begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Reads come straight from the flops: a same-edge write is not forwarded.
    assign rdata_a = regs_q[raddr_a];
    assign rdata_b = regs_q[raddr_b];

    for (genvar g = 0; g < NREGS; g++) begin : g_snap
        assign snap[g*WIDTH +: WIDTH] = regs_q[g];
    end

endmodule

// File: rtl/f_reg_file_ctrl.sv
// F-register file with call/return snapshot control toward the f-register backup stack.
module f_reg_file_ctrl
    import f_reg_file_ctrl_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF,
    parameter int unsigned AW     = $clog2(NREGS),
    parameter int unsigned SNAP_W = snap_width(NREGS, WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [AW-1:0]     raddr_a,
    input  logic [AW-1:0]     raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    input  logic              call,
    input  logic              ret,
    output logic              busy,
    output logic              overflow,
    output logic              underflow,
    output logic [SNAP_W-1:0] snap_out,
    output logic              fbs_backup,
    output logic              fbs_restore,
    input  logic [SNAP_W-1:0] fbs_data_in,
    input  logic              fbs_restore_valid
);

    localparam int unsigned DW = $clog2(DEPTH + 1);
    localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);

    state_e        state_q, state_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          busy_q, busy_d;
    logic          backup_q, backup_d;
    logic          restore_q, restore_d;
    logic          wr_en;
    logic          load_en;

    assign wr_en   = we && (state_q == IDLE);
    assign load_en = (state_q == RESTORE_WAIT) && fbs_restore_valid;

    always_comb begin
        state_d     = state_q;
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        case (state_q)
            IDLE: begin
                // call has priority; a simultaneous ret is dropped.
                if (call) begin
                    if (depth_q != DEPTH_MAX) state_d = BACKUP;
                    else                      overflow_d = 1'b1;
                end else if (ret) begin
                    if (depth_q != '0) state_d = RESTORE_WAIT;
                    else               underflow_d = 1'b1;
                end
            end
            BACKUP: begin
                depth_d = depth_q + 1'b1;
                state_d = IDLE;
            end
            RESTORE_WAIT: begin
                if (fbs_restore_valid) begin
                    depth_d = depth_q - 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        backup_d  = (state_d == BACKUP);
        restore_d = (state_d == RESTORE_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            depth_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            busy_q      <= 1'b0;
            backup_q    <= 1'b0;
            restore_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            busy_q      <= busy_d;
            backup_q    <= backup_d;
            restore_q   <= restore_d;
        end
    end

    assign busy        = busy_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign fbs_backup  = backup_q;
    assign fbs_restore = restore_q;

    f_reg_array #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (AW),
        .SNAP_W(SNAP_W)
    ) u_regs (
        .clk      (clk),
        .reset    (reset),
        .we       (wr_en),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .load     (load_en),
        .load_data(fbs_data_in),
        .snap     (snap_out)
    );

endmodule
